// File: rtl/euler_row_sequencer.sv
// Row/step sequencer for an Euler solver: RUN -> ROW_END -> DATA_RDY per row, DONE after num_steps sweeps.
// One state change per falling edge; stalls in any busy state until F/R/D arrives, bounded by the watchdog.
module euler_row_sequencer #(
    parameter  int NUM_ROWS  = 4,
    parameter  int STEP_W    = 16,
    parameter  int TMO_LIMIT = 1024,
    localparam int ROW_W     = ($clog2(NUM_ROWS) < 1) ? 1 : $clog2(NUM_ROWS),
    localparam int TMO_W     = ($clog2(TMO_LIMIT + 1) < 1) ? 1 : $clog2(TMO_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              rst_sync,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              F,
    input  logic              R,
    input  logic              D,
    input  logic              abort,
    output logic [2:0]        state,
    output logic [ROW_W-1:0]  row_idx,
    output logic [STEP_W-1:0] step_cnt,
    output logic              busy,
    output logic              end_of_row,
    output logic              data_ready,
    output logic              solve_done,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_RUN      = 3'b001,
        S_ROW_END  = 3'b010,
        S_DATA_RDY = 3'b011,
        S_DONE     = 3'b100
    } state_t;

    localparam int TMO_LAST = (TMO_LIMIT == 0) ? 0 : TMO_LIMIT - 1;
    localparam int ROW_LAST = NUM_ROWS - 1;

    state_t              r_state, w_state_nxt;
    logic [ROW_W-1:0]    r_row, w_row_nxt;
    logic [STEP_W-1:0]   r_step, w_step_nxt;
    logic [STEP_W-1:0]   r_nsteps, w_nsteps_nxt;
    logic [TMO_W-1:0]    r_wdog, w_wdog_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                w_busy;
    logic                w_await;
    logic                w_wd_fire;
    logic [STEP_W-1:0]   w_step_inc;

    always_ff @(negedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(negedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_row     <= '0;
            r_step    <= '0;
            r_nsteps  <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_row     <= w_row_nxt;
            r_step    <= w_step_nxt;
            r_nsteps  <= w_nsteps_nxt;
            r_wdog    <= w_wdog_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_step_nxt    = r_step;
        w_nsteps_nxt  = r_nsteps;
        w_timeout_nxt = r_timeout;
        w_step_inc    = r_step + 1'b1;
        w_busy        = (r_state == S_RUN) || (r_state == S_ROW_END) || (r_state == S_DATA_RDY);

        // Only the input the current state is waiting on can move it or hold off the watchdog.
        case (r_state)
            S_RUN:      w_await = F;
            S_ROW_END:  w_await = R;
            S_DATA_RDY: w_await = D;
            default:    w_await = 1'b0;
        endcase

        w_wd_fire = (TMO_LIMIT != 0) && w_busy && !w_await && (r_wdog == TMO_W'(TMO_LAST));

        if (rst_sync) begin
            w_state_nxt   = S_IDLE;
            w_row_nxt     = '0;
            w_step_nxt    = '0;
            w_nsteps_nxt  = '0;
            w_timeout_nxt = 1'b0;
        end else if (abort && w_busy) begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = '0;
        end else if (w_wd_fire) begin
            w_state_nxt   = S_IDLE;
            w_row_nxt     = '0;
            w_timeout_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_nsteps_nxt  = num_steps;
                        w_row_nxt     = '0;
                        w_step_nxt    = '0;
                        w_timeout_nxt = 1'b0;
                        w_state_nxt   = (num_steps != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (F) w_state_nxt = S_ROW_END;
                end
                S_ROW_END: begin
                    if (R) w_state_nxt = S_DATA_RDY;
                end
                S_DATA_RDY: begin
                    if (D) begin
                        if (r_row == ROW_W'(ROW_LAST)) begin
                            w_row_nxt   = '0;
                            w_step_nxt  = w_step_inc;
                            w_state_nxt = (w_step_inc == r_nsteps) ? S_DONE : S_RUN;
                        end else begin
                            w_row_nxt   = r_row + 1'b1;
                            w_state_nxt = S_RUN;
                        end
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (rst_sync || !w_busy || (w_state_nxt != r_state)) begin
            w_wdog_nxt = '0;
        end else begin
            w_wdog_nxt = r_wdog + 1'b1;
        end
    end

    assign state      = r_state;
    assign row_idx    = r_row;
    assign step_cnt   = r_step;
    assign busy       = (r_state == S_RUN) || (r_state == S_ROW_END) || (r_state == S_DATA_RDY);
    assign end_of_row = r_state[1];
    assign data_ready = (r_state == S_DATA_RDY);
    assign solve_done = (r_state == S_DONE);
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_euler_row_sequencer.sv
// Bench for euler_row_sequencer (NUM_ROWS=3, TMO_LIMIT=8): directed cycles with expectations queued per edge.
module tb_euler_row_sequencer;

    localparam int NR = 3;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_async = 1'b1;
    logic          rst_sync = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic          F = 1'b0;
    logic          R = 1'b0;
    logic          D = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    state;
    logic [1:0]    row_idx;
    logic [SW-1:0] step_cnt;
    logic          busy, end_of_row, data_ready, solve_done, timeout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        int         row;
        int         stp;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, ROW_END = 3'd2, DATA_RDY = 3'd3, DONE = 3'd4;

    euler_row_sequencer #(
        .NUM_ROWS  (NR),
        .STEP_W    (SW),
        .TMO_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst_async  (rst_async),
        .rst_sync   (rst_sync),
        .start      (start),
        .num_steps  (num_steps),
        .F          (F),
        .R          (R),
        .D          (D),
        .abort      (abort),
        .state      (state),
        .row_idx    (row_idx),
        .step_cnt   (step_cnt),
        .busy       (busy),
        .end_of_row (end_of_row),
        .data_ready (data_ready),
        .solve_done (solve_done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {busy, end_of_row, data_ready, solve_done} implied by a state code
    function automatic logic [3:0] flags_of(input logic [2:0] s);
        logic b;
        b = (s == RUN) || (s == ROW_END) || (s == DATA_RDY);
        return {b, (s == ROW_END) || (s == DATA_RDY), s == DATA_RDY, s == DONE};
    endfunction

    task automatic compare_outputs(input exp_t e);
        check({e.tag, ".state"}, 32'(state), 32'(e.st));
        check({e.tag, ".row"},   32'(row_idx), 32'(e.row));
        check({e.tag, ".step"},  32'(step_cnt), 32'(e.stp));
        check({e.tag, ".tmo"},   32'(timeout), 32'(e.tmo));
        check({e.tag, ".flags"}, 32'({busy, end_of_row, data_ready, solve_done}), 32'(flags_of(e.st)));
    endtask

    // Drive one cycle of inputs, queue what must follow the next falling edge, then compare.
    task automatic cyc(input string tag, input logic st_i, input int ns,
                       input logic f, input logic r, input logic d, input logic ab,
                       input logic [2:0] es, input int er, input int ep, input logic et);
        exp_t e;
        start     = st_i;
        num_steps = SW'(ns);
        F = f; R = r; D = d; abort = ab;
        sb.push_back('{tag, es, er, ep, et});
        @(negedge clk);
        #1;
        e = sb.pop_front();
        compare_outputs(e);
    endtask

    task automatic idle_in(input string tag, input logic [2:0] es, input int er, input int ep, input logic et);
        cyc(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, es, er, ep, et);
    endtask

    initial begin
        #3;
        compare_outputs('{"por", IDLE, 0, 0, 1'b0});
        @(posedge clk);
        rst_async = 1'b0;

        // Two full steps over three rows
        cyc("s2.start", 1'b1, 2, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < NR; r++) begin
                cyc("s2.F", 1'b0, 0, 1, 0, 0, 0, ROW_END, r, s, 1'b0);
                cyc("s2.R", 1'b0, 0, 0, 1, 0, 0, DATA_RDY, r, s, 1'b0);
                if (r < NR - 1)
                    cyc("s2.D", 1'b0, 0, 0, 0, 1, 0, RUN, r + 1, s, 1'b0);
                else if (s == 0)
                    cyc("s2.Dwrap", 1'b0, 0, 0, 0, 1, 0, RUN, 0, 1, 1'b0);
                else
                    cyc("s2.Ddone", 1'b0, 0, 0, 0, 1, 0, DONE, 0, 2, 1'b0);
            end
        end
        idle_in("s2.idle", IDLE, 0, 2, 1'b0);
        idle_in("s2.hold", IDLE, 0, 2, 1'b0);

        // F/R/D all held high: exactly one transition per edge
        cyc("frd.start", 1'b1, 1, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        for (int r = 0; r < NR; r++) begin
            cyc("frd.a", 1'b0, 0, 1, 1, 1, 0, ROW_END, r, 0, 1'b0);
            cyc("frd.b", 1'b0, 0, 1, 1, 1, 0, DATA_RDY, r, 0, 1'b0);
            if (r < NR - 1)
                cyc("frd.c", 1'b0, 0, 1, 1, 1, 0, RUN, r + 1, 0, 1'b0);
            else
                cyc("frd.done", 1'b0, 0, 1, 1, 1, 0, DONE, 0, 1, 1'b0);
        end
        cyc("frd.idle", 1'b0, 0, 1, 1, 1, 0, IDLE, 0, 1, 1'b0);

        // Watchdog in ROW_END: 8 cycles with R low
        cyc("wd.start", 1'b1, 1, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        cyc("wd.F", 1'b0, 0, 1, 0, 0, 0, ROW_END, 0, 0, 1'b0);
        for (int k = 1; k < 8; k++) idle_in("wd.wait", ROW_END, 0, 0, 1'b0);
        idle_in("wd.fire", IDLE, 0, 0, 1'b1);
        idle_in("wd.sticky", IDLE, 0, 0, 1'b1);

        // Zero-step solve: DONE for one cycle, clears timeout, never busy
        cyc("z.start", 1'b1, 0, 0, 0, 0, 0, DONE, 0, 0, 1'b0);
        idle_in("z.idle", IDLE, 0, 0, 1'b0);

        // Awaited input on the limit cycle beats the watchdog
        cyc("wl.start", 1'b1, 1, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        for (int k = 1; k < 8; k++) idle_in("wl.wait", RUN, 0, 0, 1'b0);
        cyc("wl.F", 1'b0, 0, 1, 0, 0, 0, ROW_END, 0, 0, 1'b0);
        cyc("wl.abort", 1'b0, 0, 0, 0, 0, 1, IDLE, 0, 0, 1'b0);

        // Abort in DATA_RDY at row 1; start ignored while busy
        cyc("ab.start", 1'b1, 2, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        cyc("ab.F0", 1'b0, 0, 1, 0, 0, 0, ROW_END, 0, 0, 1'b0);
        cyc("ab.R0", 1'b0, 0, 0, 1, 0, 0, DATA_RDY, 0, 0, 1'b0);
        cyc("ab.D0", 1'b0, 0, 0, 0, 1, 0, RUN, 1, 0, 1'b0);
        cyc("ab.F1", 1'b0, 0, 1, 0, 0, 0, ROW_END, 1, 0, 1'b0);
        cyc("ab.R1", 1'b0, 0, 0, 1, 0, 0, DATA_RDY, 1, 0, 1'b0);
        cyc("ab.ignst", 1'b1, 0, 0, 0, 0, 0, DATA_RDY, 1, 0, 1'b0);
        cyc("ab.abort", 1'b0, 0, 0, 0, 1, 1, IDLE, 0, 0, 1'b0);
        idle_in("ab.idle", IDLE, 0, 0, 1'b0);

        // Async reset mid-solve after one completed step
        cyc("ar.start", 1'b1, 2, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        for (int r = 0; r < NR; r++) begin
            cyc("ar.F", 1'b0, 0, 1, 0, 0, 0, ROW_END, r, 0, 1'b0);
            cyc("ar.R", 1'b0, 0, 0, 1, 0, 0, DATA_RDY, r, 0, 1'b0);
            cyc("ar.D", 1'b0, 0, 0, 0, 1, 0, RUN, (r + 1) % NR, (r == NR - 1) ? 1 : 0, 1'b0);
        end
        cyc("ar.F", 1'b0, 0, 1, 0, 0, 0, ROW_END, 0, 1, 1'b0);
        cyc("ar.R", 1'b0, 0, 0, 1, 0, 0, DATA_RDY, 0, 1, 1'b0);
        cyc("ar.D", 1'b0, 0, 0, 0, 1, 0, RUN, 1, 1, 1'b0);
        F = 1'b0; R = 1'b0; D = 1'b0;
        #2;
        rst_async = 1'b1;
        #1;
        compare_outputs('{"ar.imm", IDLE, 0, 0, 1'b0});
        #1;
        rst_async = 1'b0;
        idle_in("ar.after", IDLE, 0, 0, 1'b0);

        // Sync reset with F in RUN
        cyc("sr.start", 1'b1, 1, 0, 0, 0, 0, RUN, 0, 0, 1'b0);
        rst_sync = 1'b1;
        cyc("sr.rst", 1'b0, 0, 1, 0, 0, 0, IDLE, 0, 0, 1'b0);
        rst_sync = 1'b0;
        idle_in("sr.idle", IDLE, 0, 0, 1'b0);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
